mmult_accel_mul_arbiter: RTL and testbench

- Shares one pipelined signed multiplier (fixed latency MUL_LATENCY, clock-enabled, no internal valid) between two requesters in the matmul accelerator.
- Arbitrates issue slots round-robin, drives the multiplier operands and its `ce`, and tracks a valid/tag shift register so each product returns to the requester that issued it.
- Handles global stall, because the multiplier freezes when `ce` is low, and keeps per-requester issue counters for the host.

---
 rtl/mmult_accel_mul_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mmult_accel_mul_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmult_accel_mul_arbiter.sv
// -----------------------------------------------------------------------------
// mmult_accel_mul_arbiter
//
// Shares one external pipelined signed multiplier between two requesters of
// the matmul accelerator. The multiplier has a fixed latency of MUL_LATENCY
// clock-enabled edges and carries no valid of its own, so this block keeps a
// parallel {valid, id} tag pipeline that advances exactly when the multiplier
// does. Each product is steered back to the requester that issued it.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   stall                   global hold: no issue, multiplier and tags freeze
//   req0_valid/a/b/ready    requester 0 operand pair handshake
//   req1_valid/a/b/ready    requester 1 operand pair handshake
//   mul_ce                  multiplier clock enable (= ~stall)
//   mul_din0, mul_din1      multiplier operands
//   mul_dout                multiplier product (already truncated)
//   res_data                product of the retiring entry (= mul_dout)
//   res0_valid, res1_valid  res_data belongs to requester 0 / 1
//   busy                    at least one product in flight
//   issued0_cnt/issued1_cnt accepted-request counters, wrap modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module mmult_accel_mul_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int MUL_LATENCY = 4,   // legal range 1..8
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,

    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  req1_ready,

    output logic                  mul_ce,
    output logic [DATA_WIDTH-1:0] mul_din0,
    output logic [DATA_WIDTH-1:0] mul_din1,
    input  logic [DATA_WIDTH-1:0] mul_dout,

    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res0_valid,
    output logic                  res1_valid,
    output logic                  busy,

    output logic [CNT_WIDTH-1:0]  issued0_cnt,
    output logic [CNT_WIDTH-1:0]  issued1_cnt
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                   last_q;   // id of the most recent grant
    logic [MUL_LATENCY-1:0] tag_vld;  // entry holds a real product
    logic [MUL_LATENCY-1:0] tag_id;   // requester that issued the entry

    logic arb_en;
    logic grant0;
    logic grant1;
    logic grant_any;

    // The multiplier is frozen exactly when the tag pipeline is frozen, so the
    // two stay aligned through any pattern of stalls. It is left running during
    // reset; whatever it computes then is never tagged valid.
    assign mul_ce = ~stall;

    // -------------------------------------------------------------------------
    // Round-robin arbitration (combinational)
    // -------------------------------------------------------------------------
    assign arb_en = ~stall & ~reset;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_en) begin
            if (req0_valid && req1_valid) begin
                // On a tie the requester that was not served last wins.
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign grant_any  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // -------------------------------------------------------------------------
    // Operand mux: requester 0 is the idle default; a bubble's operands are
    // don't-care because its tag entry is invalid.
    // -------------------------------------------------------------------------
    always_comb begin
        mul_din0 = req0_a;
        mul_din1 = req0_b;
        if (grant1) begin
            mul_din0 = req1_a;
            mul_din1 = req1_b;
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (grant_any) begin
            last_q <= grant1;
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline: valids are reset so in-flight products are discarded; ids
    // are qualified by the valids and therefore carry no reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
        end else if (mul_ce) begin
            tag_vld[0] <= grant_any;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
            end
        end
    end

    // NOTE: the id array is pure datapath storage; leaving it out of reset
    // keeps it free of reset fan-out, and nothing reads it without a valid.
    always_ff @(posedge clk) begin
        if (mul_ce) begin
            tag_id[0] <= grant1;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result steering: the last tag entry lines up with mul_dout. A stalled
    // cycle presents nothing; the entry is presented on the next free cycle.
    // -------------------------------------------------------------------------
    assign res_data   = mul_dout;
    assign res0_valid = tag_vld[MUL_LATENCY-1] & ~tag_id[MUL_LATENCY-1] & ~stall & ~reset;
    assign res1_valid = tag_vld[MUL_LATENCY-1] &  tag_id[MUL_LATENCY-1] & ~stall & ~reset;
    assign busy       = (|tag_vld) & ~reset;

    // -------------------------------------------------------------------------
    // Issue counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            issued0_cnt <= '0;
            issued1_cnt <= '0;
        end else begin
            if (grant0) issued0_cnt <= issued0_cnt + CNT_WIDTH'(1);
            if (grant1) issued1_cnt <= issued1_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mmult_accel_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmult_accel_mul_arbiter
//
// Directed bench for mmult_accel_mul_arbiter with a behavioural clock-enabled
// multiplier. Stimulus pushes the expected {id, product, cycle} of each accepted
// pair into a queue; an independent monitor pops and compares every result the
// DUT presents.
// -----------------------------------------------------------------------------
module tb_mmult_accel_mul_arbiter;

    localparam int DW  = 64;
    localparam int LAT = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready;
    logic          mul_ce;
    logic [DW-1:0] mul_din0, mul_din1, mul_dout;
    logic [DW-1:0] res_data;
    logic          res0_valid, res1_valid, busy;
    logic [CW-1:0] issued0_cnt, issued1_cnt;

    mmult_accel_mul_arbiter #(
        .DATA_WIDTH (DW),
        .MUL_LATENCY(LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_ce     (mul_ce),
        .mul_din0   (mul_din0),
        .mul_din1   (mul_din1),
        .mul_dout   (mul_dout),
        .res_data   (res_data),
        .res0_valid (res0_valid),
        .res1_valid (res1_valid),
        .busy       (busy),
        .issued0_cnt(issued0_cnt),
        .issued1_cnt(issued1_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural pipelined multiplier: product truncated to DW bits.
    logic [DW-1:0] mstage [LAT];
    initial for (int i = 0; i < LAT; i++) mstage[i] = '0;
    always @(posedge clk) begin
        if (mul_ce) begin
            mstage[0] <= $signed(mul_din0) * $signed(mul_din1);
            for (int i = 1; i < LAT; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_dout = mstage[LAT-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        int unsigned   at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input logic id, input logic [DW-1:0] data, input int unsigned at);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented result must match the head of the queue.
    always @(negedge clk) begin
        if (res0_valid || res1_valid) begin
            check("one_res_valid", {63'd0, res0_valid & res1_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_result", {63'd0, res1_valid}, 64'd2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_id",    {63'd0, res1_valid}, {63'd0, e.id});
                check("res_data",  res_data, e.data);
                check("res_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0;
        req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        idle_inputs();
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            step();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (4) step();
    endtask

    int unsigned base;
    int          gaps;

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        idle_inputs();

        // ---------------- Reset state, with both requesters asserting -------
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        @(negedge clk);
        check("rst_ready0", {63'd0, req0_ready}, 64'd0);
        check("rst_ready1", {63'd0, req1_ready}, 64'd0);
        check("rst_busy",   {63'd0, busy}, 64'd0);
        check("rst_res",    {62'd0, res1_valid, res0_valid}, 64'd0);
        check("rst_cnt0",   64'(issued0_cnt), 64'd0);
        check("rst_mul_ce", {63'd0, mul_ce}, 64'd1);

        // ---------------- Single issue --------------------------------------
        do_reset();
        step();
        base = cyc;
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = -64'sd3;
        push(1'b0, -64'sd21, base + 4);
        @(negedge clk);
        check("single_ready0", {63'd0, req0_ready}, 64'd1);
        check("single_ready1", {63'd0, req1_ready}, 64'd0);
        step();
        req0_valid = 1'b0;
        drain();
        check("single_cnt0", 64'(issued0_cnt), 64'd1);
        check("single_cnt1", 64'(issued1_cnt), 64'd0);

        // ---------------- Tie and round-robin -------------------------------
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) base = cyc;
            req0_valid = 1'b1; req0_a = 64'd2; req0_b = 64'd3;
            req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd5;
            push(k[0], k[0] ? 64'd25 : 64'd6, base + k + 4);
            @(negedge clk);
            check("rr_ready0", {63'd0, req0_ready}, {63'd0, ~k[0]});
            check("rr_ready1", {63'd0, req1_ready}, {63'd0, k[0]});
        end
        step();
        idle_inputs();
        drain();
        check("rr_cnt0", 64'(issued0_cnt), 64'd3);
        check("rr_cnt1", 64'(issued1_cnt), 64'd3);

        // ---------------- Stall mid-flight ----------------------------------
        do_reset();
        step();                                   // cycle 0
        base = cyc;
        req1_valid = 1'b1; req1_a = -64'sd4; req1_b = 64'd4;
        push(1'b1, -64'sd16, base + 6);
        @(negedge clk);
        check("stall_ready1_c0", {63'd0, req1_ready}, 64'd1);
        check("stall_busy_c0",   {63'd0, busy}, 64'd0);
        step();                                   // cycle 1
        req1_valid = 1'b0;
        @(negedge clk);
        check("stall_busy_c1",   {63'd0, busy}, 64'd1);
        check("stall_ce_c1",     {63'd0, mul_ce}, 64'd1);
        for (int k = 2; k < 4; k++) begin         // cycles 2..3 stalled
            step();
            stall = 1'b1;
            req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd3;
            @(negedge clk);
            check("stall_ce_low",   {63'd0, mul_ce}, 64'd0);
            check("stall_no_grant", {62'd0, req1_ready, req0_ready}, 64'd0);
            check("stall_busy",     {63'd0, busy}, 64'd1);
        end
        step();                                   // cycle 4
        stall = 1'b0;
        push(1'b0, 64'd9, base + 8);
        @(negedge clk);
        check("stall_ready0_c4", {63'd0, req0_ready}, 64'd1);
        check("stall_busy_c4",   {63'd0, busy}, 64'd1);
        step();                                   // cycle 5
        req0_valid = 1'b0;
        @(negedge clk);
        check("stall_busy_c5", {63'd0, busy}, 64'd1);
        step();                                   // cycle 6
        @(negedge clk);
        check("stall_busy_c6", {63'd0, busy}, 64'd1);
        drain();

        // ---------------- Signed / truncation boundaries --------------------
        do_reset();
        step();
        base = cyc;
        req0_valid = 1'b1; req0_a = 64'h8000_0000_0000_0000; req0_b = '1;
        push(1'b0, 64'h8000_0000_0000_0000, base + 4);
        @(negedge clk);
        check("bnd_ready0", {63'd0, req0_ready}, 64'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 64'h0000_0000_FFFF_FFFF; req1_b = 64'h0000_0001_0000_0001;
        push(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, base + 5);
        @(negedge clk);
        check("bnd_ready1", {63'd0, req1_ready}, 64'd1);
        step();
        idle_inputs();
        drain();

        // ---------------- Reset mid-operation -------------------------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) base = cyc;
            req0_valid = 1'b1; req0_a = 64'(k + 1); req0_b = 64'(k + 1);
            @(negedge clk);
            check("midrst_issue", {63'd0, req0_ready}, 64'd1);
        end
        step();                                   // cycle 3: reset
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_res_c3",  {62'd0, res1_valid, res0_valid}, 64'd0);
        check("midrst_busy_c3", {63'd0, busy}, 64'd0);
        for (int k = 4; k < 9; k++) begin
            step();
            reset = 1'b0;
            @(negedge clk);
            check("midrst_res",  {62'd0, res1_valid, res0_valid}, 64'd0);
            check("midrst_busy", {63'd0, busy}, 64'd0);
            check("midrst_cnt0", 64'(issued0_cnt), 64'd0);
        end
        step();                                   // cycle 9: tie
        req0_valid = 1'b1; req0_a = 64'd4; req0_b = 64'd4;
        req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd5;
        push(1'b0, 64'd16, base + 13);
        @(negedge clk);
        check("midrst_tie_ready0", {63'd0, req0_ready}, 64'd1);
        check("midrst_tie_ready1", {63'd0, req1_ready}, 64'd0);
        step();                                   // cycle 10
        req0_valid = 1'b0;
        push(1'b1, 64'd25, base + 14);
        @(negedge clk);
        check("midrst_ready1", {63'd0, req1_ready}, 64'd1);
        step();
        idle_inputs();
        drain();

        // ---------------- Counter wrap --------------------------------------
        do_reset();
        gaps = 0;
        for (int i = 0; i < 65536; i++) begin
            step();
            if (i == 0) base = cyc;
            req0_valid = 1'b1; req0_a = 64'(i); req0_b = 64'd3;
            push(1'b0, 64'(i) * 64'd3, base + i + 4);
            @(negedge clk);
            if (!req0_ready) gaps++;
            if (i == 65535) check("wrap_cnt_before", 64'(issued0_cnt), 64'd65535);
        end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("wrap_cnt_after", 64'(issued0_cnt), 64'd0);
        check("wrap_gaps",      64'(gaps), 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
